// File: rtl/iwdg_pkg.sv
// Shared constants for the windowed independent watchdog.
package iwdg_pkg;

  // KR key values (low 16 bits of the KR write)
  localparam logic [15:0] KEY_ACCESS = 16'h5555;
  localparam logic [15:0] KEY_START  = 16'hCCCC;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;

  // Register byte offsets from BASE_ADR
  localparam logic [7:0] OFS_KR   = 8'h00;
  localparam logic [7:0] OFS_PR   = 8'h04;
  localparam logic [7:0] OFS_RLR  = 8'h08;
  localparam logic [7:0] OFS_SR   = 8'h0C;
  localparam logic [7:0] OFS_WINR = 8'h10;
  localparam logic [7:0] OFS_EWCR = 8'h14;
  localparam logic [7:0] OFS_CNT  = 8'h18;
  localparam logic [7:0] OFS_END  = 8'h1C;

  // SR bit positions
  localparam int SR_RUN   = 0;
  localparam int SR_UNLK  = 1;
  localparam int SR_EWIF  = 2;
  localparam int SR_FIRED = 3;

  // PR values at or above this select the maximum divider (256)
  localparam int PR_SAT = 6;

endpackage

// File: rtl/iwdg_prescaler.sv
// Tick-enable divider: counts ticks while running and emits a dec pulse
// on every wrap. The PR value is sampled only at wrap or clear so a PR
// write never shortens or stretches the period in progress.
module iwdg_prescaler
  import iwdg_pkg::*;
#(
  parameter int PR_W = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tick_i,
  input  logic            run_i,
  input  logic            clr_i,
  input  logic [PR_W-1:0] pr_i,
  output logic            dec_o
);

  logic [PR_W-1:0] pr_q;
  logic [7:0]      pcnt_q;
  logic [7:0]      lim;

  // Terminal count D-1 for D = 4<<pr, saturating at 256
  always_comb begin
    lim = 8'hFF;
    if (32'(pr_q) < PR_SAT) lim = 8'((32'd4 << pr_q) - 32'd1);
  end

  assign dec_o = run_i & tick_i & (pcnt_q == lim);

  // Divider count; clear has priority and also resamples PR
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
      pr_q   <= '0;
    end else if (clr_i) begin
      pcnt_q <= '0;
      pr_q   <= pr_i;
    end else if (run_i && tick_i) begin
      if (pcnt_q == lim) begin
        pcnt_q <= '0;
        pr_q   <= pr_i;
      end else begin
        pcnt_q <= pcnt_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/iwdg_window.sv
// Windowed independent watchdog with early warning, key-lock protocol
// and a Wishbone classic slave (ack for mapped, err for unmapped).
module iwdg_window
  import iwdg_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h0100_0000,
  parameter int          CNT_W    = 12,
  parameter int          PR_W     = 3
) (
  input  logic        clk_m2s,
  input  logic        rst_m2s,
  input  logic        tick_en,
  input  logic [31:0] dat_m2s,
  input  logic [31:0] adr_m2s,
  input  logic [3:0]  sel_m2s,
  input  logic        cyc_m2s,
  input  logic        stb_m2s,
  input  logic        we_m2s,
  output logic [31:0] dat_s2m,
  output logic        ack_s2m,
  output logic        err_s2m,
  output logic        rty_s2m,
  output logic        rst_iwdg,
  output logic        irq_ew
);

  logic [31:0]      ofs, rdat, dat_q;
  logic [7:0]       aofs;
  logic             mapped, req, wr, rd, ack_q, err_q;
  logic [CNT_W-1:0] wm;
  logic [PR_W-1:0]  pr_q;
  logic [CNT_W-1:0] rlr_q, winr_q, ewc_q, cnt_q, cnt_d;
  logic             ewie_q;
  logic             run_q, run_d, unlk_q, unlk_d, ewif_q, ewif_d;
  logic             fired_q, fired_d, rst_iwdg_q, rst_iwdg_d;
  logic             kr_wr, key_ok, k_start, k_rel, is_rel, win_bad;
  logic             do_load, sr_clr, dec;
  logic             unused_ok;

  assign ofs    = adr_m2s - BASE_ADR;
  assign aofs   = {ofs[7:2], 2'b00};
  assign mapped = (ofs[31:5] == '0) && (aofs != OFS_END);
  assign req    = cyc_m2s & stb_m2s & ~ack_q & ~err_q;
  assign wr     = req & we_m2s & mapped;
  assign rd     = req & ~we_m2s & mapped;

  assign unused_ok = ^{ofs[1:0], dat_m2s[30:16]};

  // Per-bit write mask derived from the byte lane selects
  always_comb begin
    wm = '0;
    for (int i = 0; i < CNT_W; i++) wm[i] = sel_m2s[i/8];
  end

  // Key decode; only a full low-halfword write carries a key
  assign kr_wr   = wr && (aofs == OFS_KR);
  assign key_ok  = kr_wr && (sel_m2s[1:0] == 2'b11);
  assign k_start = key_ok && (dat_m2s[15:0] == KEY_START);
  assign k_rel   = key_ok && (dat_m2s[15:0] == KEY_RELOAD);
  // Once running, start behaves as a reload and is window-checked too
  assign is_rel  = ~rst_iwdg_q & run_q & (k_start | k_rel);
  assign win_bad = is_rel && (cnt_q > winr_q);
  assign do_load = ~rst_iwdg_q & (k_start | (k_rel & run_q)) & ~win_bad;
  assign sr_clr  = wr && (aofs == OFS_SR) && sel_m2s[0] && dat_m2s[SR_EWIF];

  iwdg_prescaler #(.PR_W(PR_W)) u_psc (
    .clk_i  (clk_m2s),
    .rst_i  (rst_m2s),
    .tick_i (tick_en),
    .run_i  (run_q & ~rst_iwdg_q),
    .clr_i  (do_load),
    .pr_i   (pr_q),
    .dec_o  (dec)
  );

  // Counter, lock and status next state; reload beats dec, EWIF set beats clear
  always_comb begin
    cnt_d      = cnt_q;
    run_d      = run_q;
    unlk_d     = unlk_q;
    ewif_d     = ewif_q;
    fired_d    = fired_q;
    rst_iwdg_d = rst_iwdg_q;
    if (kr_wr) unlk_d = key_ok && (dat_m2s[15:0] == KEY_ACCESS);
    if (sr_clr) ewif_d = 1'b0;
    if (do_load) begin
      cnt_d = rlr_q;
      run_d = 1'b1;
    end else if (dec) begin
      if (cnt_q == '0) begin
        rst_iwdg_d = 1'b1;
        fired_d    = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        if (ewie_q && (cnt_d == ewc_q)) ewif_d = 1'b1;
      end
    end
    if (win_bad) rst_iwdg_d = 1'b1;
  end

  // Watchdog state registers
  always_ff @(posedge clk_m2s or posedge rst_m2s) begin
    if (rst_m2s) begin
      cnt_q      <= '1;
      run_q      <= 1'b0;
      unlk_q     <= 1'b0;
      ewif_q     <= 1'b0;
      fired_q    <= 1'b0;
      rst_iwdg_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      unlk_q     <= unlk_d;
      ewif_q     <= ewif_d;
      fired_q    <= fired_d;
      rst_iwdg_q <= rst_iwdg_d;
    end
  end

  // Configuration registers; writes while locked are acked and dropped
  always_ff @(posedge clk_m2s or posedge rst_m2s) begin
    if (rst_m2s) begin
      pr_q   <= '0;
      rlr_q  <= '1;
      winr_q <= '1;
      ewc_q  <= '0;
      ewie_q <= 1'b0;
    end else if (wr && unlk_q) begin
      case (aofs)
        OFS_PR:   if (sel_m2s[0]) pr_q <= dat_m2s[PR_W-1:0];
        OFS_RLR:  rlr_q  <= (rlr_q  & ~wm) | (dat_m2s[CNT_W-1:0] & wm);
        OFS_WINR: winr_q <= (winr_q & ~wm) | (dat_m2s[CNT_W-1:0] & wm);
        OFS_EWCR: begin
          ewc_q <= (ewc_q & ~wm) | (dat_m2s[CNT_W-1:0] & wm);
          if (sel_m2s[3]) ewie_q <= dat_m2s[31];
        end
        default: ;
      endcase
    end
  end

  // Read data mux; unused bits read as zero
  always_comb begin
    rdat = '0;
    case (aofs)
      OFS_PR:   rdat[PR_W-1:0]  = pr_q;
      OFS_RLR:  rdat[CNT_W-1:0] = rlr_q;
      OFS_SR: begin
        rdat[SR_RUN]   = run_q;
        rdat[SR_UNLK]  = unlk_q;
        rdat[SR_EWIF]  = ewif_q;
        rdat[SR_FIRED] = fired_q;
      end
      OFS_WINR: rdat[CNT_W-1:0] = winr_q;
      OFS_EWCR: begin
        rdat[CNT_W-1:0] = ewc_q;
        rdat[31]        = ewie_q;
      end
      OFS_CNT:  rdat[CNT_W-1:0] = cnt_q;
      default: ;
    endcase
  end

  // Bus termination and registered read data
  always_ff @(posedge clk_m2s or posedge rst_m2s) begin
    if (rst_m2s) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req & mapped;
      err_q <= req & ~mapped;
      if (rd) dat_q <= rdat;
    end
  end

  assign dat_s2m  = dat_q;
  assign ack_s2m  = ack_q;
  assign err_s2m  = err_q;
  assign rty_s2m  = 1'b0;
  assign rst_iwdg = rst_iwdg_q;
  assign irq_ew   = ewif_q & ewie_q;

endmodule
